// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter
//   Captures rising edges of N_CH filtered pulse levels, timestamps each one
//   against a free-running cycle counter, and presents them one at a time on a
//   shared valid/ready event port using round-robin arbitration. A channel
//   that rises again while its previous event is still waiting has the new
//   edge dropped and its sticky lost flag set.
// Ports
//   clk, rst     clock, synchronous active-high reset
//   pulse_filt   filtered pulse levels (synchronous to clk)
//   enable       global capture enable; pending events still drain when 0
//   ch_mask      per-channel capture enable
//   lost_clr     single-cycle pulse clearing lost_flags
//   evt_valid    event presented on evt_ch / evt_ts
//   evt_ready    consumer accepts when evt_valid & evt_ready
//   evt_ch       channel index of the presented event
//   evt_ts       timestamp of that channel's rising edge
//   lost_flags   sticky per-channel edge-dropped flags
module pulse_event_arbiter #(
    parameter int N_CH  = 32,
    parameter int IDX_W = 5,
    parameter int TS_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   pulse_filt,
    input  logic              enable,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic              lost_clr,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDX_W-1:0]  evt_ch,
    output logic [TS_W-1:0]   evt_ts,
    output logic [N_CH-1:0]   lost_flags
);

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    state_t            state;
    logic [TS_W-1:0]   ts_cnt;
    logic [N_CH-1:0]   prev;
    logic              prime;
    logic [N_CH-1:0]   pending;
    logic [TS_W-1:0]   ts_q [N_CH];
    logic [IDX_W-1:0]  rr_ptr;

    logic [N_CH-1:0]   cap;
    logic [N_CH-1:0]   lost_new;
    logic [N_CH-1:0]   gnt_vec;
    logic              gnt_found;
    logic [IDX_W-1:0]  gnt_idx;
    logic              do_grant;

    // prime masks edges in the first cycle after reset so that levels already
    // high at reset release never look like rising edges.
    assign cap = {N_CH{prime & enable}} & pulse_filt & ~prev & ch_mask;

    // Round-robin search starting just after the last granted channel.
    always_comb begin : find_grant
        int unsigned j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            j = (32'(rr_ptr) + k) % N_CH;
            if (!gnt_found && pending[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
    end

    // The output slot is free when idle or when the presented event is taken.
    assign do_grant = gnt_found && ((state == IDLE) || evt_ready);

    always_comb begin
        gnt_vec = '0;
        if (do_grant) gnt_vec[gnt_idx] = 1'b1;
    end

    // A granted channel counts as cleared, so a same-cycle capture wins.
    assign lost_new = cap & pending & ~gnt_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ts_cnt     <= '0;
            prev       <= '0;
            prime      <= 1'b0;
            pending    <= '0;
            rr_ptr     <= IDX_W'(N_CH - 1);
            evt_valid  <= 1'b0;
            evt_ch     <= '0;
            evt_ts     <= '0;
            lost_flags <= '0;
            for (int unsigned i = 0; i < N_CH; i++) ts_q[i] <= '0;
        end else begin
            ts_cnt     <= ts_cnt + 1'b1;
            prime      <= 1'b1;
            prev       <= pulse_filt;
            lost_flags <= (lost_flags & ~{N_CH{lost_clr}}) | lost_new;
            pending    <= (pending & ~gnt_vec) | cap;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (cap[i] && !lost_new[i]) ts_q[i] <= ts_cnt;
            end

            if (do_grant) begin
                evt_ch    <= gnt_idx;
                evt_ts    <= ts_q[gnt_idx];
                rr_ptr    <= gnt_idx;
                evt_valid <= 1'b1;
                state     <= SEND;
            end else if (state == SEND && evt_ready) begin
                evt_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule
